// File: rtl/cs_pkg.sv
// Shared definitions for the sequential carry-save resolver.
// Holds the default operand/chunk geometry and the FSM state encoding
// used by cs_resolve_seq and its interface.
package cs_pkg;

  localparam int CS_WIDTH  = 43;
  localparam int CS_CHUNK  = 11;
  localparam int CS_NCHUNK = (CS_WIDTH + CS_CHUNK - 1) / CS_CHUNK;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/cs_resolve_seq_if.sv
// Handshake bundle between a carry-save producer and the resolver.
//   in_valid/in_ready : offer/accept of the pair c_in/s_in
//   out_valid/out_ready : present/consume of sum_out/cout
// master = producer/consumer side, slave = resolver side.
interface cs_resolve_seq_if
  import cs_pkg::*;
#(
  parameter int WIDTH = CS_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] s_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

  modport master (
    output in_valid, c_in, s_in, out_ready,
    input  in_ready, out_valid, sum_out, cout
  );

  modport slave (
    input  in_valid, c_in, s_in, out_ready,
    output in_ready, out_valid, sum_out, cout
  );
endinterface

// File: rtl/cpa_chunk.sv
// One chunk of the carry-propagate adder: sum/co = a + b + cin.
//   a, b : W-bit chunk operands
//   cin  : carry from the previous chunk
//   sum  : W-bit chunk result
//   co   : carry out of the chunk's top bit
module cpa_chunk
  import cs_pkg::*;
#(
  parameter int W = CS_CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/cs_resolve_seq.sv
// Sequential carry-save resolver: turns a (c, s) pair into c + s by
// rippling one CHUNK-bit slice per cycle through a single cpa_chunk.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any operation in flight
//   bus : slave side of cs_resolve_seq_if (pair in, result out)
// Accept in IDLE, NCHUNK BUSY cycles, then DONE until out_ready.
module cs_resolve_seq
  import cs_pkg::*;
#(
  parameter int WIDTH = CS_WIDTH,
  parameter int CHUNK = CS_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  cs_resolve_seq_if.slave  bus
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;              // operands padded to whole chunks
  localparam int LAST_W = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic             cout_r;
  logic [PW-1:0]    c_r, s_r;
  logic [WIDTH-1:0] res_r;

  logic [31:0]      base;
  logic [CHUNK-1:0] ch_sum;
  logic             ch_co;
  logic [CHUNK:0]   ch_ext;
  logic             last;

  assign base = 32'(k) * CHUNK;
  assign last = (k == KW'(NCHUNK - 1));

  cpa_chunk #(.W(CHUNK)) u_cpa (
    .a   (c_r[base +: CHUNK]),
    .b   (s_r[base +: CHUNK]),
    .cin (carry),
    .sum (ch_sum),
    .co  (ch_co)
  );

  // The last chunk is zero-padded above WIDTH, so the true carry out of
  // bit WIDTH-1 is bit LAST_W of the chunk result (co when LAST_W == CHUNK).
  assign ch_ext = {ch_co, ch_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      k      <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      c_r    <= '0;
      s_r    <= '0;
      res_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          c_r   <= PW'(bus.c_in);
          s_r   <= PW'(bus.s_in);
          k     <= '0;
          carry <= 1'b0;
          res_r <= '0;
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          // res_r was cleared on accept, so OR-ing the shifted slice writes
          // bits [k*CHUNK +: CHUNK]; anything above WIDTH falls off.
          res_r <= res_r | (WIDTH'(ch_sum) << base);
          carry <= ch_co;
          k     <= k + KW'(1);
          if (last) begin
            cout_r <= ch_ext[LAST_W];
            state  <= ST_DONE;
          end
        end
        ST_DONE: if (bus.out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Results are gated so partial sums never leak while out_valid is low.
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.sum_out   = (state == ST_DONE) ? res_r : '0;
  assign bus.cout      = (state == ST_DONE) ? cout_r : 1'b0;

endmodule

// File: tb/tb_cs_resolve_seq.sv
// Self-checking bench for cs_resolve_seq at default geometry (43/11).
// A countdown model predicts handshake timing and c+s every cycle; a
// negedge compare process checks the DUT against it, and directed tests
// pin literal results, latency, DONE hold, reset abort and throughput.
module tb_cs_resolve_seq;
  localparam int W   = 43;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cs_resolve_seq_if #(.WIDTH(W)) bus ();

  cs_resolve_seq #(.WIDTH(W), .CHUNK(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Reference model: after an accept the result appears NCH cycles later
  // and stays until consumed; reset wipes anything in flight.
  int           m_left   = 0;
  logic         m_done   = 1'b0;
  logic [W:0]   m_exp    = '0;
  int           edge_cnt = 0;
  int           hs_cnt   = 0;
  int           last_hs  = 0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (bus.out_ready) begin
        m_done  <= 1'b0;
        hs_cnt  <= hs_cnt + 1;
        last_hs <= edge_cnt + 1;
      end
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (bus.in_valid) begin
      m_left <= NCH;
      m_exp  <= {1'b0, bus.c_in} + {1'b0, bus.s_in};
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  64'(bus.in_ready),  64'(!m_done && m_left == 0));
      chk("out_valid", 64'(bus.out_valid), 64'(m_done));
      chk("sum_out",   64'(bus.sum_out),   64'(m_done ? m_exp[W-1:0] : {W{1'b0}}));
      chk("cout",      64'(bus.cout),      64'(m_done ? m_exp[W] : 1'b0));
    end
  end

  // Offer one pair, measure cycles to out_valid, hold DONE for `hold`
  // cycles while poking in_valid, then consume.
  task automatic run_pair(input logic [W-1:0] c, input logic [W-1:0] s, input int hold,
                          output logic [W-1:0] rs, output logic rc, output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("in_ready_wait", 64'(bus.in_ready), 64'(1));
    bus.c_in = c; bus.s_in = s; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.c_in = rnd(); bus.s_in = rnd();
      lat++;
    end while (!bus.out_valid && lat < 20);
    rs = bus.sum_out;
    rc = bus.cout;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.c_in = rnd(); bus.s_in = rnd();
      @(negedge clk);
      chk("hold_sum",      64'(bus.sum_out),   64'(rs));
      chk("hold_cout",     64'(bus.cout),      64'(rc));
      chk("hold_in_ready", 64'(bus.in_ready),  64'(0));
      chk("hold_valid",    64'(bus.out_valid), 64'(1));
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("released", 64'(bus.out_valid), 64'(0));
  endtask

  logic [W-1:0] rs, c, s;
  logic         rc;
  logic [W:0]   e;
  int           lat, guard, hs0, cyc_start;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.c_in = '0; bus.s_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_sum",       64'(bus.sum_out),   64'(0));
    chk("rst_cout",      64'(bus.cout),      64'(0));
    rst = 1'b0;
    chk_en = 1'b1;

    // zero operands, latency pinned to NCHUNK+1
    run_pair('0, '0, 0, rs, rc, lat);
    chk("zero_lat",  64'(lat), 64'(5));
    chk("zero_sum",  64'(rs),  64'(0));
    chk("zero_cout", 64'(rc),  64'(0));

    // carry ripples through every chunk
    run_pair(43'h7FF_FFFF_FFFF, 43'h1, 0, rs, rc, lat);
    chk("ripple_sum",  64'(rs), 64'(0));
    chk("ripple_cout", 64'(rc), 64'(1));
    chk("model_pin",   64'(m_exp), 64'h800_0000_0000);

    // chunk 0 -> chunk 1 boundary
    run_pair(43'h7FF, 43'h1, 0, rs, rc, lat);
    chk("bnd_sum",  64'(rs), 64'h800);
    chk("bnd_cout", 64'(rc), 64'(0));

    // all ones + all ones, and a lone top-bit carry
    run_pair('1, '1, 0, rs, rc, lat);
    chk("ones_sum",  64'(rs), 64'h7FF_FFFF_FFFE);
    chk("ones_cout", 64'(rc), 64'(1));
    run_pair(43'h400_0000_0000, 43'h400_0000_0000, 0, rs, rc, lat);
    chk("top_sum",  64'(rs), 64'(0));
    chk("top_cout", 64'(rc), 64'(1));

    // DONE held 6 cycles with a stray in_valid
    c = rnd(); s = rnd();
    e = {1'b0, c} + {1'b0, s};
    run_pair(c, s, 6, rs, rc, lat);
    chk("hold6_sum",  64'(rs), 64'(e[W-1:0]));
    chk("hold6_cout", 64'(rc), 64'(e[W]));

    // reset in the 2nd BUSY cycle aborts the pair
    bus.c_in = 43'h7FF_FFFF_FFFF; bus.s_in = 43'h7FF_FFFF_FFFF; bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_in_ready",  64'(bus.in_ready),  64'(1));
    chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
    chk("abort_sum",       64'(bus.sum_out),   64'(0));
    repeat (8) @(negedge clk);
    c = rnd(); s = rnd();
    e = {1'b0, c} + {1'b0, s};
    run_pair(c, s, 0, rs, rc, lat);
    chk("after_abort_sum",  64'(rs), 64'(e[W-1:0]));
    chk("after_abort_cout", 64'(rc), 64'(e[W]));

    // 1000 back-to-back pairs, consumer always ready
    bus.out_ready = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
    hs0 = hs_cnt;
    cyc_start = edge_cnt;
    bus.c_in = rnd(); bus.s_in = rnd(); bus.in_valid = 1'b1;
    guard = 0;
    while (hs_cnt < hs0 + 1000 && guard < 8000) begin
      @(negedge clk);
      guard++;
      if (bus.in_ready) begin
        case ($urandom_range(0, 3))
          0: begin c = rnd(); s = rnd(); end
          1: begin c = '1;    s = rnd(); end
          2: begin c = rnd(); s = ~c;    end
          default: begin c = rnd(); s = ~c + 1'b1; end
        endcase
        bus.c_in = c; bus.s_in = s;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_count",  64'(hs_cnt - hs0),       64'(1000));
    chk("b2b_cycles", 64'(last_hs - cyc_start), 64'(6000));
    repeat (12) @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cs_resolve_seq.md
CS_RESOLVE_SEQ -- requirements
Module: cs_resolve_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 43: operand width of the carry-save pair and of the result.
REQ-002 The block SHALL have parameter CHUNK, default 11: bits resolved per cycle; NCHUNK = ceil(WIDTH/CHUNK), 4 at defaults.
REQ-003 The block SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1: carry-save pair on c_in/s_in is offered.
REQ-006 The block SHALL have port in_ready  output  1: block can accept a pair this cycle.
REQ-007 The block SHALL have port c_in  input  WIDTH: carry word of the carry-save pair; bit 0 is used as given.
REQ-008 The block SHALL have port s_in  input  WIDTH: sum word of the carry-save pair.
REQ-009 The block SHALL have port out_valid  output  1: sum_out/cout hold a resolved result.
REQ-010 The block SHALL have port out_ready  input  1: consumer takes the result this cycle.
REQ-011 The block SHALL have port sum_out  output  WIDTH: (c_in + s_in) mod 2^WIDTH.
REQ-012 The block SHALL have port cout  output  1: carry out of bit WIDTH-1 of c_in + s_in.

Function
REQ-013 States SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 IDLE with in_valid = 1 SHALL register c_in, s_in, clear chunk index and carry, and go to BUSY; in_valid = 0 stays in IDLE.
REQ-015 Each BUSY cycle SHALL add chunk k of the registered c and s plus the running carry, write the CHUNK-bit result into sum_out bits [k*CHUNK +: CHUNK], latch the chunk carry, and increment k.
REQ-016 The last chunk SHALL be WIDTH - (NCHUNK-1)*CHUNK bits wide (10 at defaults); its carry SHALL become cout; BUSY SHALL then go to DONE.
REQ-017 Latency SHALL be exactly NCHUNK+1 cycles from the accept edge to out_valid = 1 (5 at defaults).
REQ-018 DONE SHALL hold sum_out, cout, out_valid stable until out_ready = 1, then go to IDLE; the next pair is accepted no earlier than the following cycle.
REQ-019 in_valid, c_in, s_in SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-020 The result SHALL be exact for all operands, including all-ones inputs and carries rippling through every chunk boundary.
REQ-021 sum_out and cout SHALL be zero in IDLE and BUSY; partial results SHALL never be visible while out_valid = 0.

Reset
REQ-022 rst = 1 SHALL at the next edge force IDLE, in_ready = 1, out_valid = 0, sum_out = 0, cout = 0, k = 0, and clear the operand registers.
REQ-023 rst asserted in BUSY or DONE SHALL abort the operation; no result for the aborted pair is ever presented.
REQ-024 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-025 Default WIDTH, CHUNK, the derived NCHUNK, and the state encoding type SHALL live in shared package cs_pkg.
REQ-026 The per-chunk adder SHALL be sub-module cpa_chunk (inputs a, b, cin; outputs sum, co); the FSM, counter and registers stay in cs_resolve_seq.

Verification
REQ-027 c_in = 0, s_in = 0, in_valid pulse -> out_valid exactly 5 cycles after accept, sum_out = 0, cout = 0.
REQ-028 c_in = 43'h7FF_FFFF_FFFF, s_in = 43'h1 -> sum_out = 0, cout = 1 (carry ripples through all 4 chunks).
REQ-029 c_in = 43'h7FF, s_in = 43'h1 -> sum_out = 43'h800, cout = 0 (chunk 0 to chunk 1 boundary).
REQ-030 Random pair, out_ready held low 6 cycles in DONE -> sum_out/cout stable, in_ready = 0 throughout, a second in_valid ignored; result correct on release.
REQ-031 rst pulsed in the 2nd BUSY cycle -> next cycle IDLE, in_ready = 1, out_valid = 0, sum_out = 0; a new pair then resolves correctly.
REQ-032 1000 back-to-back random pairs with out_ready = 1 -> every result equals (c_in + s_in) against a reference model, one result per 6 cycles.
